// File: rtl/sys_defs.sv
// sys_defs: shared bus command encodings, widths and arbiter owner ids
package sys_defs;
  localparam int XLEN = 32;
  localparam int MEM_TAG_W = 4;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } ARB_OWNER;
endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: per-tag {valid, owner} record of outstanding memory loads
module mem_tag_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  ARB_OWNER             alloc_owner,
  input  logic                 clr_en,
  input  logic [MEM_TAG_W-1:0] clr_tag,
  input  logic [MEM_TAG_W-1:0] rd_tag,
  output logic                 rd_valid,
  output ARB_OWNER             rd_owner,
  output logic                 alloc_hit
);
  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] owner;
  // Allocation is written after the clear so a same-tag alloc wins
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= '0;
      owner <= '0;
    end else begin
      if (clr_en) valid[clr_tag] <= 1'b0;
      if (alloc_en) begin
        valid[alloc_tag] <= 1'b1;
        owner[alloc_tag] <= alloc_owner;
      end
    end
  end
  // A live entry being retired this same cycle is not a collision
  always_comb begin
    rd_valid  = valid[rd_tag];
    rd_owner  = ARB_OWNER'(owner[rd_tag]);
    alloc_hit = alloc_en && valid[alloc_tag] && !(clr_en && clr_tag == alloc_tag);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache, routes returns by tag
module mem_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS   = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           icache2ctlr_command,
  input  logic [XLEN-1:0]      icache2ctlr_addr,
  input  logic [1:0]           dcache2ctlr_command,
  input  logic [XLEN-1:0]      dcache2ctlr_addr,
  input  logic [63:0]          dcache2ctlr_data,
  input  logic [MEM_TAG_W-1:0] mem2ctlr_response,
  input  logic [63:0]          mem2ctlr_data,
  input  logic [MEM_TAG_W-1:0] mem2ctlr_tag,
  output logic [1:0]           ctlr2mem_command,
  output logic [XLEN-1:0]      ctlr2mem_addr,
  output logic [63:0]          ctlr2mem_data,
  output logic [MEM_TAG_W-1:0] Ctlr2proc_response,
  output logic [63:0]          Ctlr2proc_data,
  output logic [MEM_TAG_W-1:0] Ctlr2proc_tag,
  output logic [MEM_TAG_W-1:0] Ctlr2icache_response,
  output logic [63:0]          Ctlr2icache_data,
  output logic [MEM_TAG_W-1:0] Ctlr2icache_tag,
  output logic                 tag_err
);
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve_cnt;
  logic tag_err_q, d_req, i_req, grant_d, grant_i, resp_ok, alloc_en, ret_vld, hit;
  logic rd_valid, alloc_hit;
  ARB_OWNER rd_owner;
  // Grant, accept steering and return routing; everything is zero while in reset
  always_comb begin
    d_req = dcache2ctlr_command != BUS_NONE;
    i_req = icache2ctlr_command != BUS_NONE;
    grant_d = reset && d_req && (starve_cnt < SW'(MAX_STARVE) || !i_req);
    grant_i = reset && i_req && !grant_d;
    resp_ok = mem2ctlr_response != '0;
    ctlr2mem_command = grant_d ? dcache2ctlr_command : grant_i ? icache2ctlr_command : BUS_NONE;
    ctlr2mem_addr = grant_d ? dcache2ctlr_addr : grant_i ? icache2ctlr_addr : '0;
    ctlr2mem_data = grant_d ? dcache2ctlr_data : '0;
    Ctlr2proc_response = grant_d ? mem2ctlr_response : '0;
    Ctlr2icache_response = grant_i ? mem2ctlr_response : '0;
    alloc_en = (grant_d || grant_i) && resp_ok && ctlr2mem_command == BUS_LOAD;
    ret_vld = reset && mem2ctlr_tag != '0;
    hit = ret_vld && rd_valid;
    Ctlr2proc_tag = hit && rd_owner == OWNER_DCACHE ? mem2ctlr_tag : '0;
    Ctlr2proc_data = hit && rd_owner == OWNER_DCACHE ? mem2ctlr_data : '0;
    Ctlr2icache_tag = hit && rd_owner == OWNER_ICACHE ? mem2ctlr_tag : '0;
    Ctlr2icache_data = hit && rd_owner == OWNER_ICACHE ? mem2ctlr_data : '0;
    tag_err = reset && tag_err_q;
  end
  // Count consecutive cycles icache asks but is not accepted, saturating
  always_ff @(posedge clock) begin
    if (!reset) starve_cnt <= '0;
    else if (i_req && !(grant_i && resp_ok))
      starve_cnt <= starve_cnt == SW'(MAX_STARVE) ? starve_cnt : starve_cnt + 1'b1;
    else starve_cnt <= '0;
  end
  // Sticky flag for orphan returns and accepts onto a live tag
  always_ff @(posedge clock) begin
    if (!reset) tag_err_q <= 1'b0;
    else tag_err_q <= tag_err_q || (ret_vld && !rd_valid) || alloc_hit;
  end
  mem_tag_table #(.NUM_TAGS(NUM_TAGS)) u_table (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_tag  (mem2ctlr_response),
    .alloc_owner(grant_d ? OWNER_DCACHE : OWNER_ICACHE),
    .clr_en     (hit),
    .clr_tag    (mem2ctlr_tag),
    .rd_tag     (mem2ctlr_tag),
    .rd_valid   (rd_valid),
    .rd_owner   (rd_owner),
    .alloc_hit  (alloc_hit)
  );
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, accept steering and tag return routing
module tb_mem_arbiter;
  import sys_defs::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [1:0] icmd, dcmd, mcmd;
  logic [XLEN-1:0] iaddr, daddr, maddr;
  logic [63:0] ddata, mdata_in, mdata_out, pdata, idata;
  logic [3:0] mresp, mtag, presp, ptag, iresp, itag;
  logic terr;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .icache2ctlr_command(icmd), .icache2ctlr_addr(iaddr),
    .dcache2ctlr_command(dcmd), .dcache2ctlr_addr(daddr), .dcache2ctlr_data(ddata),
    .mem2ctlr_response(mresp), .mem2ctlr_data(mdata_in), .mem2ctlr_tag(mtag),
    .ctlr2mem_command(mcmd), .ctlr2mem_addr(maddr), .ctlr2mem_data(mdata_out),
    .Ctlr2proc_response(presp), .Ctlr2proc_data(pdata), .Ctlr2proc_tag(ptag),
    .Ctlr2icache_response(iresp), .Ctlr2icache_data(idata), .Ctlr2icache_tag(itag),
    .tag_err(terr)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [1:0] dc, input logic [XLEN-1:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [XLEN-1:0] ia, input logic [3:0] rs,
                       input logic [3:0] tg, input logic [63:0] md);
    dcmd = dc; daddr = da; ddata = dd; icmd = ic; iaddr = ia;
    mresp = rs; mtag = tg; mdata_in = md;
    #1;
  endtask
  task automatic idle();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 0, 0);
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    idle();
    tick();
    reset = 1'b1;
  endtask
  initial begin
    drive(BUS_LOAD, 32'h100, 64'h1, BUS_LOAD, 32'h200, 4'd3, 4'd3, 64'h5);
    check("rst_cmd", mcmd, BUS_NONE);
    check("rst_addr", maddr, 0);
    check("rst_presp", presp, 0);
    check("rst_iresp", iresp, 0);
    check("rst_tags", {ptag, itag}, 0);
    tick();
    tick();
    reset = 1'b1;
    drive(BUS_LOAD, 32'h1000, 0, BUS_NONE, 0, 4'd3, 0, 0);
    check("t1_addr", maddr, 32'h1000);
    check("t1_cmd", mcmd, BUS_LOAD);
    check("t1_presp", presp, 3);
    check("t1_iresp", iresp, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd3, 64'hDEADBEEF_CAFEF00D);
    check("t2_ptag", ptag, 3);
    check("t2_pdata", pdata, 64'hDEADBEEF_CAFEF00D);
    check("t2_itag", itag, 0);
    check("t2_err0", terr, 0);
    tick();
    check("t2_orphan_ptag", ptag, 0);
    tick();
    idle();
    check("t2_err1", terr, 1);
    do_reset();
    check("t3_err_clr", terr, 0);
    for (int i = 0; i < 10; i++) begin
      drive(BUS_LOAD, 32'h3000, 64'h77, BUS_LOAD, 32'h2000, 4'd5, 0, 0);
      check($sformatf("t3_addr%0d", i), maddr, (i % 5 == 4) ? 32'h2000 : 32'h3000);
      check($sformatf("t3_iresp%0d", i), iresp, (i % 5 == 4) ? 5 : 0);
      check($sformatf("t3_presp%0d", i), presp, (i % 5 == 4) ? 0 : 5);
      check($sformatf("t3_mdata%0d", i), mdata_out, (i % 5 == 4) ? 0 : 64'h77);
      tick();
    end
    do_reset();
    drive(BUS_LOAD, 32'h40, 0, BUS_NONE, 0, 4'd7, 0, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_LOAD, 32'h80, 4'd7, 4'd7, 64'h1111);
    check("t4_iresp", iresp, 7);
    check("t4_ptag", ptag, 7);
    check("t4_pdata", pdata, 64'h1111);
    check("t4_itag0", itag, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd7, 64'h2222);
    check("t4_itag", itag, 7);
    check("t4_idata", idata, 64'h2222);
    check("t4_ptag0", ptag, 0);
    tick();
    idle();
    check("t4_err", terr, 0);
    drive(BUS_STORE, 32'h4000, 64'h55, BUS_NONE, 0, 4'd9, 0, 0);
    check("t5_cmd", mcmd, BUS_STORE);
    check("t5_data", mdata_out, 64'h55);
    check("t5_presp", presp, 9);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd9, 64'h99);
    check("t5_tags", {ptag, itag}, 0);
    tick();
    idle();
    check("t5_err", terr, 1);
    do_reset();
    drive(BUS_LOAD, 32'h5000, 0, BUS_NONE, 0, 4'd2, 0, 0);
    tick();
    drive(BUS_LOAD, 32'h5008, 0, BUS_NONE, 0, 4'd0, 0, 0);
    check("t6_cmd", mcmd, BUS_LOAD);
    check("t6_presp", presp, 0);
    tick();
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'hAB);
    check("t6_ptag_live", ptag, 2);
    reset = 1'b0;
    drive(BUS_LOAD, 32'h5010, 0, BUS_LOAD, 32'h10, 4'd1, 4'd2, 64'hAB);
    check("t6_rst_cmd", mcmd, BUS_NONE);
    check("t6_rst_ptag", ptag, 0);
    tick();
    reset = 1'b1;
    drive(BUS_NONE, 0, 0, BUS_NONE, 0, 0, 4'd2, 64'hAB);
    check("t6_post_ptag", ptag, 0);
    tick();
    idle();
    check("t6_err", terr, 1);
    do_reset();
    drive(BUS_LOAD, 32'h6000, 0, BUS_NONE, 0, 4'd4, 0, 0);
    tick();
    idle();
    check("t7_err0", terr, 0);
    drive(BUS_LOAD, 32'h6008, 0, BUS_NONE, 0, 4'd4, 0, 0);
    tick();
    idle();
    check("t7_dup_err", terr, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
